// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package riscv_fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } fetch_state_t;

   // Sequential word address; the carry out of bit 31 is dropped so the PC wraps.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline slot: a redirect flush wins over a load, a load wins over a drain,
// and a stalled slot keeps its contents.
module if_id_reg
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] load_inst,
   input  logic [XLEN-1:0] load_pc,
   input  logic            flush,
   input  logic            flush_pc_we,
   input  logic [XLEN-1:0] flush_pc,
   input  logic            stall,
   output logic            valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc
);

   logic            valid_r;
   logic [XLEN-1:0] inst_r;
   logic [XLEN-1:0] pc_r;

   // Slot update with priority flush > load > drain > hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r <= 1'b0;
         inst_r  <= NOP_INST;
         pc_r    <= RESET_PC;
      end else if (flush) begin
         valid_r <= 1'b0;
         inst_r  <= NOP_INST;
         if (flush_pc_we) begin
            pc_r <= flush_pc;
         end
      end else if (load) begin
         valid_r <= 1'b1;
         inst_r  <= load_inst;
         pc_r    <= load_pc;
      end else if (!stall) begin
         valid_r <= 1'b0;
         inst_r  <= NOP_INST;
      end
   end

   assign valid = valid_r;
   assign inst  = inst_r;
   assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: PC, single-outstanding fetch FSM, hold buffer and IF/ID slot.
// FETCH_MISALIGN_TRAP_EN adds fetch_misalign and parks the FSM on a misaligned redirect.
module fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            id_stall,
   output logic            if_valid,
   output logic [XLEN-1:0] if_inst,
   output logic [XLEN-1:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misalign
`endif
);

   fetch_state_t    state_r;
   fetch_state_t    state_n;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pc_n;
   logic            req_valid_r;
   logic [XLEN-1:0] hold_inst_r;
   logic [XLEN-1:0] hold_pc_r;
   logic            hold_we_s;
   logic            load_s;
   logic [XLEN-1:0] load_inst_s;
   logic [XLEN-1:0] load_pc_s;
   logic            slot_free_s;
   logic [XLEN-1:0] target_s;
   logic            trap_s;
   logic            park_s;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_r;

   assign trap_s   = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign target_s = redirect_target;
   assign park_s   = misalign_r;

   // Sticky misaligned-target flag; once set the FSM stays parked until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_r <= 1'b0;
      end else if (trap_s) begin
         misalign_r <= 1'b1;
      end
   end

   assign fetch_misalign = misalign_r;
`else
   assign trap_s   = 1'b0;
   assign target_s = {redirect_target[XLEN-1:2], 2'b00};
   assign park_s   = 1'b0;
`endif

   assign slot_free_s = !if_valid || !id_stall;

   // Next-state, PC and slot/buffer load decisions.
   always_comb begin
      state_n     = state_r;
      pc_n        = pc_r;
      hold_we_s   = 1'b0;
      load_s      = 1'b0;
      load_inst_s = imem_resp_data;
      load_pc_s   = pc_r;
      if (trap_s) begin
         state_n = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (park_s) state_n = IDLE;
               else        state_n = REQ;
            end
            REQ: begin
               if (redirect_valid) begin
                  pc_n    = target_s;
                  state_n = imem_req_ready ? DROP : REQ;
               end else if (imem_req_ready) begin
                  state_n = WAIT;
               end else begin
                  state_n = REQ;
               end
            end
            WAIT: begin
               if (imem_resp_valid && redirect_valid) begin
                  pc_n    = target_s;
                  state_n = REQ;
               end else if (imem_resp_valid && slot_free_s) begin
                  load_s  = 1'b1;
                  pc_n    = next_pc(pc_r);
                  state_n = REQ;
               end else if (imem_resp_valid) begin
                  hold_we_s = 1'b1;
                  pc_n      = next_pc(pc_r);
                  state_n   = HOLD;
               end else if (redirect_valid) begin
                  pc_n    = target_s;
                  state_n = DROP;
               end else begin
                  state_n = WAIT;
               end
            end
            HOLD: begin
               load_inst_s = hold_inst_r;
               load_pc_s   = hold_pc_r;
               if (redirect_valid) begin
                  pc_n    = target_s;
                  state_n = REQ;
               end else if (!id_stall) begin
                  load_s  = 1'b1;
                  state_n = REQ;
               end else begin
                  state_n = HOLD;
               end
            end
            DROP: begin
               // The response owed to the stale request is swallowed here.
               if (redirect_valid) pc_n = target_s;
               else                pc_n = pc_r;
               if (imem_resp_valid) state_n = REQ;
               else                 state_n = DROP;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // FSM, PC, request-valid and hold buffer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         pc_r        <= RESET_PC;
         req_valid_r <= 1'b0;
         hold_inst_r <= NOP_INST;
         hold_pc_r   <= RESET_PC;
      end else begin
         state_r     <= state_n;
         pc_r        <= pc_n;
         req_valid_r <= (state_n == REQ);
         if (hold_we_s) begin
            hold_inst_r <= imem_resp_data;
            hold_pc_r   <= pc_r;
         end
      end
   end

   assign imem_req_valid = req_valid_r;
   assign imem_req_addr  = pc_r;

   if_id_reg #(
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk         (clk),
      .reset       (reset),
      .load        (load_s),
      .load_inst   (load_inst_s),
      .load_pc     (load_pc_s),
      .flush       (redirect_valid),
      .flush_pc_we (trap_s),
      .flush_pc    (redirect_target),
      .stall       (id_stall),
      .valid       (if_valid),
      .inst        (if_inst),
      .pc          (if_pc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a one-cycle-latency memory model plus a
// scoreboard of expected delivered PCs that is checked whenever decode takes the slot.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [31:0] T4_RAW = 32'h0000_0200;
`else
   localparam logic [31:0] T4_RAW = 32'h0000_0202;
`endif
   localparam logic [31:0] T4_EXP = 32'h0000_0200;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        id_stall;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   logic        mem_ready;
   logic        mem_rv = 1'b0;
   logic [31:0] mem_rd = 32'h0;
   logic        inj_rv;
   int          acc_cnt = 0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_stall        (id_stall),
      .if_valid        (if_valid),
      .if_inst         (if_inst),
      .if_pc           (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign  (fetch_misalign)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 ^ {a[23:0], 8'h00};
   endfunction

   assign imem_req_ready  = mem_ready;
   assign imem_resp_valid = mem_rv | inj_rv;
   assign imem_resp_data  = inj_rv ? 32'hDEAD_BEEF : mem_rd;

   // Memory answers every accepted request exactly one cycle later.
   always @(posedge clk) begin
      mem_rv <= imem_req_valid && mem_ready;
      mem_rd <= mem_word(imem_req_addr);
      if (imem_req_valid && mem_ready) acc_cnt <= acc_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [31:0] exp_pc;
      forever begin
         @(negedge clk);
         if (!reset && if_valid && !id_stall) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected got pc %h inst %h want no delivery", if_pc, if_inst);
            end else begin
               exp_pc = sb_q.pop_front();
               if ({if_pc, if_inst} !== {exp_pc, mem_word(exp_pc)}) begin
                  errors++;
                  $display("FAIL sb_deliver got pc %h inst %h want pc %h inst %h",
                           if_pc, if_inst, exp_pc, mem_word(exp_pc));
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      id_stall        = 1'b0;
      mem_ready       = 1'b0;
      inj_rv          = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      id_stall        = 1'b0;
      mem_ready       = 1'b0;
      inj_rv          = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc} !== {1'b0, RST_PC, 1'b0, NOP, RST_PC}) begin
         errors++;
         $display("FAIL reset_outputs got %b %h %b %h %h want 0 %h 0 %h %h",
                  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, RST_PC, NOP, RST_PC);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (fetch_misalign !== 1'b0) begin
         errors++;
         $display("FAIL reset_misalign got %b want 0", fetch_misalign);
      end
`endif
   endtask

   task automatic test_basic();
      do_reset();
      mem_ready = 1'b1;
      sb_q.push_back(32'h0);
      cyc();
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL t1_first_req got %b %h want 1 00000000", imem_req_valid, imem_req_addr);
      end
      cyc();
      checks++;
      if ({imem_req_valid, if_valid} !== 2'b00) begin
         errors++;
         $display("FAIL t1_wait got req %b if_valid %b want 0 0", imem_req_valid, if_valid);
      end
      cyc();
      checks++;
      if ({if_valid, if_inst, if_pc} !== {1'b1, 32'h0050_0093, 32'h0}) begin
         errors++;
         $display("FAIL t1_slot got %b %h %h want 1 00500093 00000000", if_valid, if_inst, if_pc);
      end
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin
         errors++;
         $display("FAIL t1_next_req got %b %h want 1 00000004", imem_req_valid, imem_req_addr);
      end
      mem_ready = 1'b0;
      cyc();
      checks++;
      if ({if_valid, if_inst, imem_req_valid, imem_req_addr} !== {1'b0, NOP, 1'b1, 32'h4}) begin
         errors++;
         $display("FAIL t1_drain_hold got %b %h %b %h want 0 %h 1 00000004",
                  if_valid, if_inst, imem_req_valid, imem_req_addr, NOP);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL t1_sb_left got %0d want 0", sb_q.size());
      end
   endtask

   task automatic test_stall_hold();
      int acc0;
      do_reset();
      acc0      = acc_cnt;
      mem_ready = 1'b1;
      sb_q.push_back(32'h0);
      sb_q.push_back(32'h4);
      repeat (3) cyc();
      id_stall = 1'b1;
      cyc();
      cyc();
      for (int i = 0; i < 3; i++) begin
         if (i != 0) cyc();
         checks++;
         if ({imem_req_valid, if_valid, if_inst, if_pc} !== {1'b0, 1'b1, mem_word(32'h0), 32'h0}) begin
            errors++;
            $display("FAIL t2_hold_%0d got req %b slot %b %h %h want 0 1 %h 00000000",
                     i, imem_req_valid, if_valid, if_inst, if_pc, mem_word(32'h0));
         end
      end
      id_stall = 1'b0;
      cyc();
      checks++;
      if ({if_valid, if_inst, if_pc} !== {1'b1, mem_word(32'h4), 32'h4}) begin
         errors++;
         $display("FAIL t2_release got %b %h %h want 1 %h 00000004", if_valid, if_inst, if_pc, mem_word(32'h4));
      end
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8} || (acc_cnt - acc0) != 2) begin
         errors++;
         $display("FAIL t2_req_count got %b %h acc %0d want 1 00000008 acc 2",
                  imem_req_valid, imem_req_addr, acc_cnt - acc0);
      end
      mem_ready = 1'b0;
      cyc();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL t2_sb_left got %0d want 0", sb_q.size());
      end
   endtask

   task automatic test_redirect_drop();
      do_reset();
      mem_ready = 1'b1;
      sb_q.push_back(32'h0);
      sb_q.push_back(32'h4);
      sb_q.push_back(32'h100);
      for (int i = 0; i < 20 && !(imem_req_valid && imem_req_addr == 32'h8); i++) cyc();
      checks++;
      if (!(imem_req_valid === 1'b1 && imem_req_addr === 32'h8)) begin
         errors++;
         $display("FAIL t3_wait_req8 got %b %h want 1 00000008", imem_req_valid, imem_req_addr);
      end
      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if ({if_valid, if_inst, imem_req_valid} !== {1'b0, NOP, 1'b0}) begin
         errors++;
         $display("FAIL t3_flush got %b %h req %b want 0 %h 0", if_valid, if_inst, imem_req_valid, NOP);
      end
      cyc();
      checks++;
      if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
         errors++;
         $display("FAIL t3_target_req got %b %h %b want 1 00000100 0", imem_req_valid, imem_req_addr, if_valid);
      end
      cyc();
      cyc();
      checks++;
      if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin
         errors++;
         $display("FAIL t3_target_slot got %b %h want 1 00000100", if_valid, if_pc);
      end
      mem_ready = 1'b0;
      cyc();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL t3_sb_left got %0d want 0", sb_q.size());
      end
   endtask

   task automatic test_redirect_resp();
      do_reset();
      mem_ready = 1'b1;
      sb_q.push_back(T4_EXP);
      for (int i = 0; i < 20 && !imem_resp_valid; i++) cyc();
      checks++;
      if (imem_resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL t4_wait_resp got %b want 1", imem_resp_valid);
      end
      redirect_valid  = 1'b1;
      redirect_target = T4_RAW;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, T4_EXP, 1'b0}) begin
         errors++;
         $display("FAIL t4_target_req got %b %h %b want 1 %h 0", imem_req_valid, imem_req_addr, if_valid, T4_EXP);
      end
      cyc();
      cyc();
      checks++;
      if ({if_valid, if_inst, if_pc} !== {1'b1, mem_word(T4_EXP), T4_EXP}) begin
         errors++;
         $display("FAIL t4_slot got %b %h %h want 1 %h %h", if_valid, if_inst, if_pc, mem_word(T4_EXP), T4_EXP);
      end
      mem_ready = 1'b0;
      cyc();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL t4_sb_left got %0d want 0", sb_q.size());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      sb_q.push_back(32'hFFFF_FFFC);
      cyc();
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         errors++;
         $display("FAIL t5_redirect_unaccepted got %b %h want 1 fffffffc", imem_req_valid, imem_req_addr);
      end
      mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      cyc();
      checks++;
      if ({if_valid, if_pc, imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL t5_wrap got %b %h req %b %h want 1 fffffffc 1 00000000",
                  if_valid, if_pc, imem_req_valid, imem_req_addr);
      end
      cyc();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL t5_sb_left got %0d want 0", sb_q.size());
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      mem_ready = 1'b1;
      repeat (3) cyc();
      id_stall = 1'b1;
      cyc();
      checks++;
      if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b1, 1'b0, 32'h4}) begin
         errors++;
         $display("FAIL t6_pre_reset got %b %b %h want 1 0 00000004", if_valid, imem_req_valid, imem_req_addr);
      end
      reset  = 1'b1;
      inj_rv = 1'b1;
      #1;
      checks++;
      if ({imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc} !== {1'b0, RST_PC, 1'b0, NOP, RST_PC}) begin
         errors++;
         $display("FAIL t6_async_reset got %b %h %b %h %h want 0 %h 0 %h %h",
                  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, RST_PC, NOP, RST_PC);
      end
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      id_stall = 1'b0;
      cyc();
      checks++;
      if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, RST_PC, 1'b0}) begin
         errors++;
         $display("FAIL t6_post_req got %b %h %b want 1 %h 0", imem_req_valid, imem_req_addr, if_valid, RST_PC);
      end
      inj_rv = 1'b0;
      sb_q.push_back(RST_PC);
      cyc();
      cyc();
      checks++;
      if ({if_valid, if_inst, if_pc} !== {1'b1, mem_word(RST_PC), RST_PC}) begin
         errors++;
         $display("FAIL t6_post_slot got %b %h %h want 1 %h %h", if_valid, if_inst, if_pc, mem_word(RST_PC), RST_PC);
      end
      mem_ready = 1'b0;
      cyc();
`ifdef FETCH_MISALIGN_TRAP_EN
      begin
         bit req_seen;
         req_seen        = 1'b0;
         redirect_valid  = 1'b1;
         redirect_target = 32'h0000_0102;
         cyc();
         redirect_valid = 1'b0;
         mem_ready      = 1'b1;
         checks++;
         if ({fetch_misalign, if_valid, if_pc} !== {1'b1, 1'b0, 32'h0000_0102}) begin
            errors++;
            $display("FAIL t6_misalign got %b %b %h want 1 0 00000102", fetch_misalign, if_valid, if_pc);
         end
         for (int i = 0; i < 5; i++) begin
            if (imem_req_valid !== 1'b0) req_seen = 1'b1;
            cyc();
         end
         checks++;
         if (req_seen || fetch_misalign !== 1'b1) begin
            errors++;
            $display("FAIL t6_parked got req_seen %b misalign %b want 0 1", req_seen, fetch_misalign);
         end
         mem_ready = 1'b0;
      end
`endif
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL t6_sb_left got %0d want 0", sb_q.size());
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_stall_hold();
      test_redirect_drop();
      test_redirect_resp();
      test_wrap();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
